// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: function-code width and the
// sixteen function codes used by alu_core and alu_pipe.
package alu_pkg;

  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FUNC_ADD  = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_ID   = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_NOT  = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_NAND = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_NOR  = 4'd7;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 4'd8;
  localparam logic [FUNC_W-1:0] FUNC_XNOR = 4'd9;
  localparam logic [FUNC_W-1:0] FUNC_LLS  = 4'd10;
  localparam logic [FUNC_W-1:0] FUNC_LRS  = 4'd11;
  localparam logic [FUNC_W-1:0] FUNC_ALS  = 4'd12;
  localparam logic [FUNC_W-1:0] FUNC_ARS  = 4'd13;
  localparam logic [FUNC_W-1:0] FUNC_TCP  = 4'd14;
  localparam logic [FUNC_W-1:0] FUNC_ZERO = 4'd15;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: computes result C and signed overflow OF
// for any of the sixteen function codes at a parametrised WIDTH.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [FUNC_W-1:0] func,
  output logic [WIDTH-1:0]  c,
  output logic              of
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] neg;

  assign sum  = a + b;
  assign diff = a - b;
  assign neg  = (~a) + ONE;

  // Only ADD and SUB can flag overflow; shifts and negation never do.
  always_comb begin
    c  = '0;
    of = 1'b0;
    case (func)
      FUNC_ADD: begin
        c  = sum;
        of = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      FUNC_SUB: begin
        c  = diff;
        of = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      FUNC_ID:   c = a;
      FUNC_NOT:  c = ~a;
      FUNC_AND:  c = a & b;
      FUNC_OR:   c = a | b;
      FUNC_NAND: c = ~(a & b);
      FUNC_NOR:  c = ~(a | b);
      FUNC_XOR:  c = a ^ b;
      FUNC_XNOR: c = ~(a ^ b);
      FUNC_LLS:  c = {a[MSB-1:0], 1'b0};
      FUNC_LRS:  c = {1'b0, a[MSB:1]};
      FUNC_ALS:  c = {a[MSB-1:0], 1'b0};
      FUNC_ARS:  c = {a[MSB], a[MSB:1]};
      FUNC_TCP:  c = neg;
      FUNC_ZERO: c = '0;
      default:   c = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU with tag passthrough and full backpressure.
// Optional sticky overflow flag enabled by defining ALU_PIPE_STICKY_OF_EN.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_c,
  output logic              out_of,
  output logic [TAG_W-1:0]  out_tag,
`ifdef ALU_PIPE_STICKY_OF_EN
  input  logic              of_clear,
  output logic              of_sticky,
`endif
  output logic              busy
);

  logic              s1_valid_reg;
  logic [WIDTH-1:0]  s1_a_reg;
  logic [WIDTH-1:0]  s1_b_reg;
  logic [FUNC_W-1:0] s1_func_reg;
  logic [TAG_W-1:0]  s1_tag_reg;

  logic              s2_valid_reg;
  logic [WIDTH-1:0]  s2_c_reg;
  logic              s2_of_reg;
  logic [TAG_W-1:0]  s2_tag_reg;

  logic [WIDTH-1:0]  core_c;
  logic              core_of;
  logic              s1_adv;
  logic              s2_adv;

  // Ready chains back combinationally so a pop and a push can share a cycle.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_func_reg  <= '0;
      s1_tag_reg   <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_a_reg    <= in_a;
        s1_b_reg    <= in_b;
        s1_func_reg <= in_func;
        s1_tag_reg  <= in_tag;
      end
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a    (s1_a_reg),
    .b    (s1_b_reg),
    .func (s1_func_reg),
    .c    (core_c),
    .of   (core_of)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_c_reg     <= '0;
      s2_of_reg    <= 1'b0;
      s2_tag_reg   <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_c_reg   <= core_c;
        s2_of_reg  <= core_of;
        s2_tag_reg <= s1_tag_reg;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_c     = s2_c_reg;
  assign out_of    = s2_of_reg;
  assign out_tag   = s2_tag_reg;
  assign busy      = s1_valid_reg || s2_valid_reg;

`ifdef ALU_PIPE_STICKY_OF_EN
  logic of_sticky_reg;

  // A set on an overflowing output transfer takes priority over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      of_sticky_reg <= 1'b0;
    end else if (s2_valid_reg && out_ready && s2_of_reg) begin
      of_sticky_reg <= 1'b1;
    end else if (of_clear) begin
      of_sticky_reg <= 1'b0;
    end
  end

  assign of_sticky = of_sticky_reg;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=16 and WIDTH=8 instances).
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_of, busy;
  logic [15:0] in_a, in_b, out_c;
  logic [3:0]  in_func, in_tag, out_tag;

  logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_out_of, w8_busy;
  logic [7:0]  w8_in_a, w8_in_b, w8_out_c;
  logic [3:0]  w8_in_func, w8_in_tag, w8_out_tag;

`ifdef ALU_PIPE_STICKY_OF_EN
  logic of_clear, of_sticky, w8_of_clear, w8_of_sticky;
`endif

  alu_pipe #(.WIDTH(16), .TAG_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_func(in_func), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_of(out_of), .out_tag(out_tag),
`ifdef ALU_PIPE_STICKY_OF_EN
    .of_clear(of_clear), .of_sticky(of_sticky),
`endif
    .busy(busy)
  );

  alu_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .reset(reset),
    .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .in_a(w8_in_a), .in_b(w8_in_b), .in_func(w8_in_func), .in_tag(w8_in_tag),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready),
    .out_c(w8_out_c), .out_of(w8_out_of), .out_tag(w8_out_tag),
`ifdef ALU_PIPE_STICKY_OF_EN
    .of_clear(w8_of_clear), .of_sticky(w8_of_sticky),
`endif
    .busy(w8_busy)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_func = '0; in_tag = '0;
    w8_in_valid = 1'b0; w8_out_ready = 1'b0; w8_in_a = '0; w8_in_b = '0;
    w8_in_func = '0; w8_in_tag = '0;
`ifdef ALU_PIPE_STICKY_OF_EN
    of_clear = 1'b0; w8_of_clear = 1'b0;
`endif
    #12;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_c !== 16'h0000) begin tests_failed++; $display("FAIL reset_out_c: got %h expected 0000", out_c); end
    tests_run++; if (out_of !== 1'b0) begin tests_failed++; $display("FAIL reset_out_of: got %b expected 0", out_of); end
    tests_run++; if (out_tag !== 4'h0) begin tests_failed++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    $display("[TB] reset released");
  endtask

  task automatic test_add_latency();
    @(negedge clk);
    in_a = 16'h7fff; in_b = 16'h0005; in_func = FUNC_ADD; in_tag = 4'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_early_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL lat_out_valid: got %b expected 1", out_valid); end
    tests_run++; if (out_c !== 16'h8004) begin tests_failed++; $display("FAIL lat_out_c: got %h expected 8004", out_c); end
    tests_run++; if (out_of !== 1'b1) begin tests_failed++; $display("FAIL lat_out_of: got %b expected 1", out_of); end
    tests_run++; if (out_tag !== 4'd3) begin tests_failed++; $display("FAIL lat_out_tag: got %h expected 3", out_tag); end
    $display("[TB] txn ADD 7fff+0005 -> c=%h of=%b tag=%0d", out_c, out_of, out_tag);
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lat_drain_valid: got %b expected 0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL lat_drain_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [3:0]  vf [3];
    logic [15:0] ec [3];
    logic        eo [3];
    va = '{16'h7fff, 16'hf001, 16'hf0f1};
    vb = '{16'hffff, 16'h1234, 16'h4321};
    vf = '{FUNC_SUB, FUNC_ARS, FUNC_TCP};
    ec = '{16'h8000, 16'hf800, 16'h0f0f};
    eo = '{1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_early_valid: got %b expected 0", out_valid); end
      end
      if (i >= 2 && i <= 4) begin
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i-2, out_valid); end
        tests_run++; if (out_c !== ec[i-2]) begin tests_failed++; $display("FAIL b2b_c[%0d]: got %h expected %h", i-2, out_c, ec[i-2]); end
        tests_run++; if (out_of !== eo[i-2]) begin tests_failed++; $display("FAIL b2b_of[%0d]: got %b expected %b", i-2, out_of, eo[i-2]); end
        tests_run++; if (out_tag !== 4'(i+5)) begin tests_failed++; $display("FAIL b2b_tag[%0d]: got %h expected %h", i-2, out_tag, 4'(i+5)); end
        $display("[TB] txn b2b[%0d] -> c=%h of=%b tag=%0d", i-2, out_c, out_of, out_tag);
      end
      if (i == 5) begin
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain_busy: got %b expected 0", busy); end
      end
      if (i < 3) begin
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
        in_a = va[i]; in_b = vb[i]; in_func = vf[i]; in_tag = 4'(i+7); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got_c [3];
    logic [3:0]  got_t [3];
    int n;
    bit op2_taken;
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 16'd1; in_b = 16'd1; in_func = FUNC_ADD; in_tag = 4'd1; in_valid = 1'b1;
    @(negedge clk);
    in_a = 16'd2; in_b = 16'd2; in_tag = 4'd2;
    @(negedge clk);
    in_a = 16'd3; in_b = 16'd3; in_tag = 4'd3;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    tests_run++; if (out_c !== 16'd2) begin tests_failed++; $display("FAIL bp_out_c: got %h expected 0002", out_c); end
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_hold: got %b expected 0", in_ready); end
    tests_run++; if (out_c !== 16'd2) begin tests_failed++; $display("FAIL bp_out_c_stable: got %h expected 0002", out_c); end
    tests_run++; if (out_tag !== 4'd1) begin tests_failed++; $display("FAIL bp_out_tag_stable: got %h expected 1", out_tag); end
    out_ready = 1'b1;
    n = 0;
    op2_taken = 1'b0;
    for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
      if (op2_taken) in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) op2_taken = 1'b1;
      if (out_valid && out_ready) begin
        got_c[n] = out_c; got_t[n] = out_tag;
        $display("[TB] txn bp[%0d] -> c=%h tag=%0d", n, out_c, out_tag);
        n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL bp_count: got %0d results expected 3", n); end
    for (int k = 0; k < n; k++) begin
      tests_run++; if (got_c[k] !== 16'(2*(k+1))) begin tests_failed++; $display("FAIL bp_c[%0d]: got %h expected %h", k, got_c[k], 16'(2*(k+1))); end
      tests_run++; if (got_t[k] !== 4'(k+1)) begin tests_failed++; $display("FAIL bp_tag[%0d]: got %h expected %h", k, got_t[k], 4'(k+1)); end
    end
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_no_dup: got out_valid %b expected 0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_drain_busy: got %b expected 0", busy); end
  endtask

  task automatic test_width8();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [3:0] vf [3];
    logic [7:0] ec [3];
    logic       eo [3];
    va = '{8'h80, 8'h81, 8'h81};
    vb = '{8'h81, 8'h00, 8'h00};
    vf = '{FUNC_ADD, FUNC_LRS, FUNC_ARS};
    ec = '{8'h01, 8'h40, 8'hc0};
    eo = '{1'b1, 1'b0, 1'b0};
    w8_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w8_in_a = va[i]; w8_in_b = vb[i]; w8_in_func = vf[i]; w8_in_tag = 4'(i+5); w8_in_valid = 1'b1;
      @(negedge clk);
      w8_in_valid = 1'b0;
      @(negedge clk);
      tests_run++; if (w8_out_valid !== 1'b1) begin tests_failed++; $display("FAIL w8_valid[%0d]: got %b expected 1", i, w8_out_valid); end
      tests_run++; if (w8_out_c !== ec[i]) begin tests_failed++; $display("FAIL w8_c[%0d]: got %h expected %h", i, w8_out_c, ec[i]); end
      tests_run++; if (w8_out_of !== eo[i]) begin tests_failed++; $display("FAIL w8_of[%0d]: got %b expected %b", i, w8_out_of, eo[i]); end
      tests_run++; if (w8_out_tag !== 4'(i+5)) begin tests_failed++; $display("FAIL w8_tag[%0d]: got %h expected %h", i, w8_out_tag, 4'(i+5)); end
      $display("[TB] txn w8[%0d] -> c=%h of=%b tag=%0d", i, w8_out_c, w8_out_of, w8_out_tag);
    end
    @(negedge clk);
    tests_run++; if (w8_busy !== 1'b0) begin tests_failed++; $display("FAIL w8_drain_busy: got %b expected 0", w8_busy); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 16'h1234; in_b = 16'h0001; in_func = FUNC_ADD; in_tag = 4'd9; in_valid = 1'b1;
    @(negedge clk);
    in_tag = 4'd10;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_valid_before: got %b expected 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid_async: got %b expected 0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy_async: got %b expected 0", busy); end
    tests_run++; if (out_c !== 16'h0000) begin tests_failed++; $display("FAIL rst_mid_out_c: got %h expected 0000", out_c); end
    $display("[TB] reset asserted mid-flight");
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_stale[%0d]: got out_valid %b expected 0", i, out_valid); end
    end
  endtask

`ifdef ALU_PIPE_STICKY_OF_EN
  task automatic test_sticky();
    out_ready = 1'b1;
    @(negedge clk);
    in_a = 16'h7fff; in_b = 16'h0001; in_func = FUNC_ADD; in_tag = 4'd1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (of_sticky !== 1'b0) begin tests_failed++; $display("FAIL sticky_pre: got %b expected 0", of_sticky); end
    @(negedge clk);
    tests_run++; if (of_sticky !== 1'b1) begin tests_failed++; $display("FAIL sticky_set: got %b expected 1", of_sticky); end
    in_a = 16'h0001; in_b = 16'h0001; in_tag = 4'd2; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (of_sticky !== 1'b1) begin tests_failed++; $display("FAIL sticky_hold: got %b expected 1", of_sticky); end
    of_clear = 1'b1;
    @(negedge clk); of_clear = 1'b0;
    tests_run++; if (of_sticky !== 1'b0) begin tests_failed++; $display("FAIL sticky_clear: got %b expected 0", of_sticky); end
    in_a = 16'h7fff; in_b = 16'h0001; in_tag = 4'd3; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    of_clear = 1'b1;
    @(negedge clk); of_clear = 1'b0;
    tests_run++; if (of_sticky !== 1'b1) begin tests_failed++; $display("FAIL sticky_set_wins: got %b expected 1", of_sticky); end
    $display("[TB] sticky overflow sequence done");
  endtask
`endif

  initial begin
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_backpressure();
    test_width8();
    test_reset_midflight();
`ifdef ALU_PIPE_STICKY_OF_EN
    test_sticky();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the 16-bit combinational ALU. It has a valid/ready handshake on input and output, full backpressure, and a tag passthrough for out-of-band tracking. It keeps the same 16 function codes and the same overflow semantics at any WIDTH. It sits between the operand-issue logic and the writeback logic, and sustains one operation per clock.

Parameters:
WIDTH, 16, operand/result width in bits (min 2)
TAG_W, 4, width of the opaque tag carried with each operation

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept; transfer when in_valid&&in_ready
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_func  in  4  function code (package constants)
in_tag  in  TAG_W  opaque tag, returned unchanged
out_valid  out  1  result available
out_ready  in  1  consumer accepts; transfer when out_valid&&out_ready
out_c  out  WIDTH  result
out_of  out  1  signed overflow flag of this result
out_tag  out  TAG_W  tag of this result
busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0. out_valid=0, out_c=0, out_of=0, out_tag=0, busy=0. in_ready=1 once reset deasserts. A reset asserted mid-operation discards all in-flight entries immediately.
- Stage 1 registers in_a, in_b, in_func and in_tag on an input transfer.
- Stage 2 registers the computed C, the OF flag and the tag; stage 2 drives the out_* ports directly.
- Latency: an op accepted at edge N is presented with out_valid=1 after edge N+1 (two register stages) when there is no stall.
- Advance rules: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. This is a combinational ready chain; no bubbles.
- Simultaneous pop at stage 2 and push from stage 1 in the same cycle: stage 2 loads the new entry and out_valid stays 1. This gives full throughput.
- Stall: while out_valid&&!out_ready, out_c/out_of/out_tag are held stable. Stage 1 holds if it is full. in_ready=0 only when both stages are full and out_ready=0.
- Data registers update only on the corresponding valid load; a stage whose valid bit is 0 keeps its stale data.
- busy = s1_valid || s2_valid.
- Functions (shifts are by exactly 1):
  - ADD: A+B mod 2^WIDTH.
  - SUB: A-B.
  - ID: A.
  - NOT: ~A.
  - AND, OR, NAND, NOR, XOR, XNOR: bitwise on A and B.
  - LLS: A<<1.
  - LRS: A>>1 with zero fill.
  - ALS: A<<1.
  - ARS: A>>>1 with sign fill.
  - TCP: ~A+1.
  - ZERO: 0.
- OF rules:
  - ADD: OF=1 iff A[MSB]==B[MSB] && C[MSB]!=A[MSB].
  - SUB: OF=1 iff A[MSB]!=B[MSB] && C[MSB]!=A[MSB].
  - All other functions: OF=0, including ALS and TCP of the most-negative value.
- in_b is ignored for unary and shift functions. All 16 codes are defined, so no illegal-code handling exists.

Optional Feature:
ALU_PIPE_STICKY_OF_EN:
- Defined: adds input of_clear (1 bit) and output of_sticky (1 bit).
  - of_sticky is set on every output transfer that has out_of=1.
  - It is cleared by of_clear.
  - If a set and a clear happen in the same cycle, the set wins.
  - Reset value of of_sticky is 0.
- Undefined: neither port exists and no extra state exists.

Decomposition:
- Shared package/header alu_pkg: the FUNC_* 4-bit codes (ADD=0, SUB=1, ID=2, NOT=3, AND=4, OR=5, NAND=6, NOR=7, XOR=8, XNOR=9, LLS=10, LRS=11, ALS=12, ARS=13, TCP=14, ZERO=15) and a FUNC_W=4 constant.
- One sub-module, alu_core: purely combinational, parametrised by WIDTH, computes C and OF. alu_pipe instantiates it between stage 1 and stage 2.

Test Plan:
- Reset, then one ADD (A=0x7fff, B=0x0005, tag=3, out_ready=1) -> out_valid=1 exactly 2 edges after accept; out_c=0x8004, out_of=1, out_tag=3.
- Back-to-back stream of SUB 0x7fff-0xffff, ARS 0xf001, TCP 0xf0f1, with out_ready held 1 -> one result per cycle, in order: 0x8000/OF=1, 0xf800/0, 0x0f0f/0.
- Backpressure: hold out_ready=0 and offer 3 ops -> first two accepted, then in_ready=0 and out_c stable. Raise out_ready -> all three delivered in order with no loss or duplication.
- WIDTH=8 instance: ADD 0x80+0x81 -> 0x01/OF=1; LRS 0x81 -> 0x40; ARS 0x81 -> 0xc0.
- Assert reset while both stages are full -> out_valid=0 and busy=0 immediately (asynchronously); no stale result appears after release.
- With ALU_PIPE_STICKY_OF_EN: ADD overflow, then ADD 1+1 -> of_sticky stays 1; of_clear pulse -> 0; of_clear in the same cycle as an overflowing output transfer -> of_sticky=1.
